// File: rtl/cpu_multicycle_control_pkg.sv
// Shared types and codes for the multicycle RV32I control FSM and its decoder.
// Latency: n/a (types, constants and one pure output-lookup function).
// Backpressure: n/a. Optional CPU_TRAP_EN build uses S_TRAP and the illegal field.
package cpu_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_RESET_WAIT = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_READ   = 4'd4,
    S_MEM_WB     = 4'd5,
    S_MEM_WRITE  = 4'd6,
    S_EXECUTE    = 4'd7,
    S_ALU_WB     = 4'd8,
    S_BRANCH     = 4'd9,
    S_JUMP       = 4'd10,
    S_UPPER      = 4'd11,
    S_TRAP       = 4'd12
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [1:0] ALU_SRC_A_PC     = 2'd0;
  localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] ALU_SRC_A_RS1    = 2'd2;
  localparam logic [1:0] ALU_SRC_A_ZERO   = 2'd3;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] RESULT_SRC_ALU_REG = 2'd0;
  localparam logic [1:0] RESULT_SRC_MEM     = 2'd1;
  localparam logic [1:0] RESULT_SRC_ALU_OUT = 2'd2;

  localparam logic JUMP_SRC_PC  = 1'b0;
  localparam logic JUMP_SRC_ALU = 1'b1;

  // Registered (Moore) control word; ir_write and the fetch pc_write are
  // handshake-qualified and therefore produced outside this struct.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       pc_write;
    logic       jump;
    logic       jump_src;
    logic       branch;
    logic [2:0] branch_cond;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       reg_write;
    logic       busy;
    logic       illegal;
  } ctrl_t;

  // Control word for a state; opcode/funct3 come from the instruction register.
  function automatic ctrl_t state_outputs(input state_t s, input logic [6:0] opcode,
                                          input logic [2:0] funct3);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_FETCH);
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = ALU_SRC_A_PC;
        c.alu_src_b = ALU_SRC_B_FOUR;
        c.alu_op    = ALU_OP_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = ALU_SRC_A_OLD_PC;
        c.alu_src_b = ALU_SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = ALU_SRC_A_RS1;
        c.alu_src_b = ALU_SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        c.mem_req  = 1'b1;
        c.addr_src = 1'b1;
      end
      S_MEM_WB: begin
        c.result_src = RESULT_SRC_MEM;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_req  = 1'b1;
        c.mem_we   = 1'b1;
        c.addr_src = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = ALU_SRC_A_RS1;
        c.alu_src_b = (opcode == OPC_OP) ? ALU_SRC_B_RS2 : ALU_SRC_B_IMM;
        c.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        c.result_src = RESULT_SRC_ALU_REG;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = ALU_SRC_A_RS1;
        c.alu_src_b   = ALU_SRC_B_RS2;
        c.alu_op      = ALU_OP_SUB;
        c.branch      = 1'b1;
        c.branch_cond = funct3;
        c.pc_write    = 1'b1;
      end
      S_JUMP: begin
        c.jump       = 1'b1;
        c.pc_write   = 1'b1;
        c.result_src = RESULT_SRC_ALU_OUT;
        c.reg_write  = 1'b1;
        if (opcode == OPC_JALR) begin
          c.jump_src  = JUMP_SRC_ALU;
          c.alu_src_a = ALU_SRC_A_RS1;
          c.alu_src_b = ALU_SRC_B_IMM;
        end else begin
          c.jump_src  = JUMP_SRC_PC;
          c.alu_src_a = ALU_SRC_A_OLD_PC;
          c.alu_src_b = ALU_SRC_B_FOUR;
        end
      end
      S_UPPER: begin
        c.alu_src_a = (opcode == OPC_LUI) ? ALU_SRC_A_ZERO : ALU_SRC_A_OLD_PC;
        c.alu_src_b = ALU_SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_TRAP: begin
        c.busy    = 1'b0;
        c.illegal = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_multicycle_control_if.sv
// Control <-> datapath/memory bundle for the multicycle control FSM.
// Latency: n/a (wires only); master = control block, slave = datapath side.
// Backpressure: memory uses req/ready; illegal_instr exists only with CPU_TRAP_EN.
interface cpu_multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_src;
  logic       ir_write;
  logic       pc_write;
  logic       jump;
  logic       jump_src;
  logic       branch;
  logic [2:0] branch_cond;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       reg_write;
  logic       busy;
`ifdef CPU_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
    input  opcode, funct3, funct7_5, mem_ready,
    output mem_req, mem_we, addr_src, ir_write, pc_write, jump, jump_src, branch,
           branch_cond, alu_src_a, alu_src_b, alu_op, result_src, reg_write, busy
`ifdef CPU_TRAP_EN
    , output illegal_instr
`endif
  );

  modport slave (
    output opcode, funct3, funct7_5, mem_ready,
    input  mem_req, mem_we, addr_src, ir_write, pc_write, jump, jump_src, branch,
           branch_cond, alu_src_a, alu_src_b, alu_op, result_src, reg_write, busy
`ifdef CPU_TRAP_EN
    , input illegal_instr
`endif
  );
endinterface

// File: rtl/cpu_multicycle_control_main_decoder.sv
// Opcode to post-DECODE state lookup for the multicycle control FSM.
// Latency: combinational, zero cycles.
// Backpressure: none. With CPU_TRAP_EN, undefined opcodes and reserved branch funct3 map to S_TRAP.
module cpu_multicycle_control_main_decoder
  import cpu_multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output state_t     next_state
);

`ifndef CPU_TRAP_EN
  // Reserved branch encodings are passed through to the branch logic.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
`endif

  // Map the latched opcode to the first state of its instruction class.
  always_comb begin
`ifdef CPU_TRAP_EN
    next_state = S_TRAP;
`else
    next_state = S_FETCH;
`endif
    case (opcode)
      OPC_LOAD, OPC_STORE: next_state = S_MEM_ADDR;
      OPC_OP, OPC_OP_IMM:  next_state = S_EXECUTE;
      OPC_BRANCH: begin
`ifdef CPU_TRAP_EN
        next_state = (funct3 == 3'd2 || funct3 == 3'd3) ? S_TRAP : S_BRANCH;
`else
        next_state = S_BRANCH;
`endif
      end
      OPC_JAL, OPC_JALR:   next_state = S_JUMP;
      OPC_LUI, OPC_AUIPC:  next_state = S_UPPER;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Main multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3 (branch/jump), 4 (ALU, upper, store), 5 (load) cycles plus memory wait states.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold mem_req until mem_ready. CPU_TRAP_EN adds TRAP state.
module cpu_multicycle_control
  import cpu_multicycle_control_pkg::*;
#(
  parameter int RESET_STALL = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cpu_multicycle_control_if.master  bus
);

  localparam int CNT_W = (RESET_STALL > 0) ? $clog2(RESET_STALL + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(RESET_STALL);
  localparam state_t RESET_STATE = (RESET_STALL > 0) ? S_RESET_WAIT : S_FETCH;

  state_t           state;
  state_t           next_state;
  state_t           dec_state;
  logic [CNT_W-1:0] stall_cnt;
  ctrl_t            ctrl_q;
  logic             mem_done;

  // funct7_5 only matters to the ALU decoder downstream.
  logic unused_funct7_5;
  assign unused_funct7_5 = bus.funct7_5;

  cpu_multicycle_control_main_decoder u_main_decoder (
    .opcode     (bus.opcode),
    .funct3     (bus.funct3),
    .next_state (dec_state)
  );

  // A ready with no request outstanding is ignored.
  assign mem_done = ctrl_q.mem_req & bus.mem_ready;

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      S_RESET_WAIT: if (stall_cnt == STALL_LAST) next_state = S_FETCH;
      S_FETCH:      if (mem_done) next_state = S_DECODE;
      S_DECODE:     next_state = dec_state;
      S_MEM_ADDR:   next_state = (bus.opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:   if (mem_done) next_state = S_MEM_WB;
      S_MEM_WRITE:  if (mem_done) next_state = S_FETCH;
      S_EXECUTE,
      S_UPPER:      next_state = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP:       next_state = S_FETCH;
      S_TRAP:       next_state = S_TRAP;
      default:      next_state = RESET_STATE;
    endcase
  end

  // State, reset-stall counter and the registered control word for the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      stall_cnt <= '0;
      ctrl_q    <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= state_outputs(next_state, bus.opcode, bus.funct3);
      if (state == S_RESET_WAIT && stall_cnt != STALL_LAST) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // The fetch handshake cycle latches the instruction and advances the PC to PC+4.
  assign bus.ir_write    = (state == S_FETCH) & mem_done;
  assign bus.pc_write    = bus.ir_write | ctrl_q.pc_write;
  assign bus.mem_req     = ctrl_q.mem_req;
  assign bus.mem_we      = ctrl_q.mem_we;
  assign bus.addr_src    = ctrl_q.addr_src;
  assign bus.jump        = ctrl_q.jump;
  assign bus.jump_src    = ctrl_q.jump_src;
  assign bus.branch      = ctrl_q.branch;
  assign bus.branch_cond = ctrl_q.branch_cond;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.result_src  = ctrl_q.result_src;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.busy        = ctrl_q.busy;

`ifdef CPU_TRAP_EN
  assign bus.illegal_instr = ctrl_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Bench for cpu_multicycle_control: randomized instruction stream against a per-instruction model.
// Latency: model predicts cycle counts from instruction class and memory wait states.
// Backpressure: a memory model stalls fetch/data requests for chosen wait counts.
module tb_cpu_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  cpu_multicycle_control_if bus ();
  cpu_multicycle_control_if bus2 ();

  cpu_multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cpu_multicycle_control #(.RESET_STALL(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  logic [20:0] outs1, outs2;
  assign outs1 = {bus.mem_req, bus.mem_we, bus.addr_src, bus.ir_write, bus.pc_write, bus.jump,
                  bus.jump_src, bus.branch, bus.branch_cond, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.result_src, bus.reg_write, bus.busy};
  assign outs2 = {bus2.mem_req, bus2.mem_we, bus2.addr_src, bus2.ir_write, bus2.pc_write, bus2.jump,
                  bus2.jump_src, bus2.branch, bus2.branch_cond, bus2.alu_src_a, bus2.alu_src_b,
                  bus2.alu_op, bus2.result_src, bus2.reg_write, bus2.busy};

  task automatic set_ir(input logic [31:0] instr);
    bus.opcode   = instr[6:0];
    bus.funct3   = instr[14:12];
    bus.funct7_5 = instr[30];
  endtask

  // Runs one instruction from its first FETCH cycle up to the next FETCH and
  // compares what was observed with what the instruction class predicts.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input string name);
    int cyc = 0, post = 0, wcnt = 0, inv = 0;
    int n_rw = 0, n_pcw = 0, n_ir = 0, n_br = 0, n_jmp = 0, n_rd = 0, n_wr = 0;
    bit ir_seen = 0, prev_wait = 0, done = 0, latch = 0;
    logic prev_addr = 1'b0, prev_we = 1'b0;
    logic [1:0] s_rs = 2'bxx, s_a1 = 2'bxx, s_b1 = 2'bxx, s_o1 = 2'bxx;
    logic [1:0] s_a2 = 2'bxx, s_b2 = 2'bxx, s_o2 = 2'bxx;
    logic [2:0] s_cond = 3'bxxx;
    logic       s_js = 1'bx;
    logic [6:0] op = instr[6:0];
    logic [2:0] f3 = instr[14:12];
    int e_cyc, e_rw = 0, e_pcw = 1, e_br = 0, e_jmp = 0, e_rd = 0, e_wr = 0;
    logic [1:0] e_rs = 2'd0, e_a = 2'd0, e_b = 2'd0, e_o = 2'd0;
    logic e_js = 1'b0;
    bit chk2 = 1, chk_op = 1;
    case (op)
      7'h03: begin e_cyc = 5 + fw + mw; e_rw = 1; e_rs = 2'd1; e_rd = 1; e_a = 2'd2; e_b = 2'd1; end
      7'h23: begin e_cyc = 4 + fw + mw; e_wr = 1; e_a = 2'd2; e_b = 2'd1; end
      7'h33: begin e_cyc = 4 + fw; e_rw = 1; e_a = 2'd2; e_b = 2'd0; e_o = 2'd2; end
      7'h13: begin e_cyc = 4 + fw; e_rw = 1; e_a = 2'd2; e_b = 2'd1; e_o = 2'd2; end
      7'h37: begin e_cyc = 4 + fw; e_rw = 1; e_a = 2'd3; e_b = 2'd1; end
      7'h17: begin e_cyc = 4 + fw; e_rw = 1; e_a = 2'd1; e_b = 2'd1; end
      7'h63: begin e_cyc = 3 + fw; e_br = 1; e_pcw = 2; e_a = 2'd2; e_b = 2'd0; e_o = 2'd1; end
      7'h6F: begin e_cyc = 3 + fw; e_jmp = 1; e_rw = 1; e_rs = 2'd2; e_pcw = 2;
                   e_a = 2'd1; e_b = 2'd2; chk_op = 0; end
      7'h67: begin e_cyc = 3 + fw; e_jmp = 1; e_js = 1'b1; e_rw = 1; e_rs = 2'd2; e_pcw = 2;
                   e_a = 2'd2; e_b = 2'd1; chk_op = 0; end
      default: begin e_cyc = 2 + fw; chk2 = 0; end
    endcase
    while (cyc < 100 && !done) begin
      if (bus.mem_req) bus.mem_ready = (wcnt == (bus.addr_src ? mw : fw));
      else bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (ir_seen && bus.mem_req && !bus.addr_src) begin
        done = 1;
      end else begin
        cyc++;
        if (bus.jump && bus.branch) inv++;
        if (!bus.branch && bus.branch_cond != 3'd0) inv++;
        if (bus.busy !== !(bus.mem_req && !bus.addr_src)) inv++;
        if (prev_wait && (bus.mem_req !== 1'b1 || bus.addr_src !== prev_addr || bus.mem_we !== prev_we)) inv++;
        if (bus.ir_write && !(bus.mem_req && !bus.addr_src && bus.mem_ready)) inv++;
`ifdef CPU_TRAP_EN
        if (bus.illegal_instr !== 1'b0) inv++;
`endif
        prev_wait = bus.mem_req && !bus.mem_ready;
        prev_addr = bus.addr_src;
        prev_we   = bus.mem_we;
        if (bus.mem_req) begin
          if (bus.mem_ready) begin
            wcnt = 0;
            if (bus.addr_src && bus.mem_we) n_wr++;
            if (bus.addr_src && !bus.mem_we) n_rd++;
          end else wcnt++;
        end
        if (bus.reg_write) begin n_rw++; s_rs = bus.result_src; end
        if (bus.pc_write) n_pcw++;
        if (bus.branch) begin n_br++; s_cond = bus.branch_cond; end
        if (bus.jump) begin n_jmp++; s_js = bus.jump_src; end
        if (post == 1) begin s_a1 = bus.alu_src_a; s_b1 = bus.alu_src_b; s_o1 = bus.alu_op; end
        if (post == 2) begin s_a2 = bus.alu_src_a; s_b2 = bus.alu_src_b; s_o2 = bus.alu_op; end
        latch = bus.ir_write;
        if (bus.ir_write) begin n_ir++; ir_seen = 1; post = 1; end
        else if (ir_seen) post++;
        @(posedge clk);
        #1;
        if (latch) set_ir(instr);
        @(negedge clk);
      end
    end
    total++; if (!done) begin bad++; $display("FAIL %s timeout: no return to fetch within %0d cycles", name, cyc); end
    total++; if (cyc != e_cyc) begin bad++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, e_cyc); end
    total++; if (inv != 0) begin bad++; $display("FAIL %s invariants: got %0d violations want 0", name, inv); end
    total++; if (n_ir != 1) begin bad++; $display("FAIL %s ir_write: got %0d want 1", name, n_ir); end
    total++; if (n_rw != e_rw) begin bad++; $display("FAIL %s reg_write: got %0d want %0d", name, n_rw, e_rw); end
    total++; if (n_pcw != e_pcw) begin bad++; $display("FAIL %s pc_write: got %0d want %0d", name, n_pcw, e_pcw); end
    total++; if (n_br != e_br) begin bad++; $display("FAIL %s branch: got %0d want %0d", name, n_br, e_br); end
    total++; if (n_jmp != e_jmp) begin bad++; $display("FAIL %s jump: got %0d want %0d", name, n_jmp, e_jmp); end
    total++; if (n_rd != e_rd || n_wr != e_wr) begin
      bad++; $display("FAIL %s data access: got rd=%0d wr=%0d want rd=%0d wr=%0d", name, n_rd, n_wr, e_rd, e_wr);
    end
    total++; if ({s_a1, s_b1, s_o1} !== {2'd1, 2'd1, 2'd0}) begin
      bad++; $display("FAIL %s decode alu: got a=%0d b=%0d op=%0d want a=1 b=1 op=0", name, s_a1, s_b1, s_o1);
    end
    if (e_rw != 0) begin
      total++; if (s_rs !== e_rs) begin bad++; $display("FAIL %s result_src: got %0d want %0d", name, s_rs, e_rs); end
    end
    if (e_br != 0) begin
      total++; if (s_cond !== f3) begin bad++; $display("FAIL %s branch_cond: got %0d want %0d", name, s_cond, f3); end
    end
    if (e_jmp != 0) begin
      total++; if (s_js !== e_js) begin bad++; $display("FAIL %s jump_src: got %0d want %0d", name, s_js, e_js); end
    end
    if (chk2) begin
      total++; if (s_a2 !== e_a || s_b2 !== e_b || (chk_op && s_o2 !== e_o)) begin
        bad++; $display("FAIL %s exec alu: got a=%0d b=%0d op=%0d want a=%0d b=%0d op=%0d",
                        name, s_a2, s_b2, s_o2, e_a, e_b, e_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_ir(32'h0);
    bus2.opcode = 7'h0; bus2.funct3 = 3'h0; bus2.funct7_5 = 1'b0; bus2.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      total++; if (outs1 !== '0 || outs2 !== '0) begin
        bad++; $display("FAIL reset outputs: got %h/%h want 0/0", outs1, outs2);
      end
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({bus.mem_req, bus.addr_src, bus.busy} !== 3'b100) begin
      bad++; $display("FAIL first fetch: got req/addr/busy=%b want 100", {bus.mem_req, bus.addr_src, bus.busy});
    end
    total++; if ({bus2.mem_req, bus2.busy} !== 2'b01) begin
      bad++; $display("FAIL stall edge1: got req/busy=%b want 01", {bus2.mem_req, bus2.busy});
    end
    @(negedge clk);
    total++; if (bus2.mem_req !== 1'b0) begin bad++; $display("FAIL stall edge2: got mem_req=%b want 0", bus2.mem_req); end
    @(negedge clk);
    total++; if ({bus2.mem_req, bus2.addr_src, bus2.busy} !== 3'b100) begin
      bad++; $display("FAIL stall edge3: got req/addr/busy=%b want 100", {bus2.mem_req, bus2.addr_src, bus2.busy});
    end
  endtask

  task automatic test_fetch_wait();
    run_instr(32'h00208033, 5, 0, "add_fetch_wait");
  endtask

  task automatic test_load_store();
    run_instr(32'h0000A103, 0, 2, "lw_stall");
    run_instr(32'h0020A023, 1, 1, "sw");
  endtask

  task automatic test_branch();
    run_instr(32'h00208463, 0, 0, "beq");
    run_instr(32'h0020F463, 2, 0, "bgeu");
  endtask

  task automatic test_jump();
    run_instr(32'h008000EF, 0, 0, "jal");
    run_instr(32'h000080E7, 1, 0, "jalr");
  endtask

  task automatic test_upper();
    run_instr(32'h123450B7, 0, 0, "lui");
    run_instr(32'h12345097, 0, 0, "auipc");
  endtask

`ifdef CPU_TRAP_EN
  task automatic test_trap(input logic [31:0] instr, input string name);
    bus.mem_ready = 1'b1;
    #1;
    total++; if (bus.ir_write !== 1'b1) begin bad++; $display("FAIL %s fetch: got ir_write=%b want 1", name, bus.ir_write); end
    @(posedge clk);
    #1;
    set_ir(instr);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      total++; if (bus.illegal_instr !== 1'b1 || outs1 !== '0) begin
        bad++; $display("FAIL %s trap hold: got illegal=%b outs=%h want 1/0", name, bus.illegal_instr, outs1);
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (bus.illegal_instr !== 1'b0) begin bad++; $display("FAIL %s trap reset: got %b want 0", name, bus.illegal_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || bus.illegal_instr !== 1'b0) begin
      bad++; $display("FAIL %s refetch: got req=%b illegal=%b want 1/0", name, bus.mem_req, bus.illegal_instr);
    end
  endtask
`endif

  task automatic test_illegal();
`ifdef CPU_TRAP_EN
    test_trap(32'h0000007F, "trap_opcode");
    test_trap(32'h0020A463, "trap_funct3");
`else
    run_instr(32'h0000007F, 0, 0, "illegal_nop");
    run_instr(32'h0020A463, 0, 0, "branch_f3_2");
`endif
  endtask

  task automatic test_random();
    logic [6:0] ops [0:12];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
            7'h7F, 7'h00, 7'h0B, 7'h73};
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [31:0] ins;
`ifdef CPU_TRAP_EN
      k = int'($urandom_range(0, 8));
`else
      k = int'($urandom_range(0, 12));
`endif
      ins = $urandom;
      ins[6:0] = ops[k];
`ifdef CPU_TRAP_EN
      if (ops[k] == 7'h63 && (ins[14:12] == 3'd2 || ins[14:12] == 3'd3)) ins[14:12] = 3'd0;
`endif
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
    end
  endtask

  task automatic test_reset_mid();
    bus.mem_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (outs1 !== '0) begin bad++; $display("FAIL mid reset drop: got %h want 0", outs1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL mid reset refetch: got %b want 1", bus.mem_req); end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_fetch_wait();
    test_load_store();
    test_branch();
    test_jump();
    test_upper();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
